// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and decode helper for alu_mc.
package alu_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_XOR    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_AND    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] sel);
    return (sel >= ALU_MUL) && (sel <= ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the EX-stage issue logic and alu_mc.
interface alu_mc_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      sel;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            zeroflag;
  logic            busy;

  modport master (
    output in_valid, sel, A, B, out_ready,
    input  in_ready, out_valid, out, zeroflag, busy
  );

  modport slave (
    input  in_valid, sel, A, B, out_ready,
    output in_ready, out_valid, out, zeroflag, busy
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply (shift-add) / restoring divide on operand magnitudes.
// Latches operands on start, runs XLEN steps, pulses done with the signed-corrected result.
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_div,
  input  logic            a_signed,
  input  logic            b_signed,
  input  logic            hi,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic            active_q, active_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mc_q, mc_d;
  logic            div_q, div_d;
  logic            hi_q, hi_d;
  logic            neg_q, neg_d;
  logic            negr_q, negr_d;
  logic            done_q, done_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, mul_add;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem;

  assign a_neg   = a_signed & a[XLEN-1];
  assign b_neg   = b_signed & b[XLEN-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign mul_add = lo_q[0] ? mc_q : '0;
  assign mul_sum = {1'b0, acc_q} + {1'b0, mul_add};
  assign div_sh  = {acc_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, mc_q};

  // Multiply: {acc, lo} is the product register, lo starts as the multiplier.
  // Divide: acc is the partial remainder, lo shifts the dividend out and the quotient in.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    mc_d     = mc_q;
    div_d    = div_q;
    hi_d     = hi_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    done_d   = 1'b0;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = CW'(XLEN - 1);
      acc_d    = '0;
      div_d    = is_div;
      hi_d     = hi;
      neg_d    = a_neg ^ b_neg;
      negr_d   = a_neg;
      lo_d     = is_div ? a_mag : b_mag;
      mc_d     = is_div ? b_mag : a_mag;
    end else if (active_q) begin
      if (div_q) begin
        if (!div_diff[XLEN]) begin
          acc_d = div_diff[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = div_sh[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_sum[XLEN:1];
        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      if (cnt_q == '0) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      mc_q     <= '0;
      div_q    <= 1'b0;
      hi_q     <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      mc_q     <= mc_d;
      div_q    <= div_d;
      hi_q     <= hi_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      done_q   <= done_d;
    end
  end

  assign prod   = {acc_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -lo_q : lo_q;
  assign rem    = negr_q ? -acc_q : acc_q;

  assign done   = done_q;
  assign result = div_q ? (hi_q ? rem : quo)
                        : (hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0]);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready handshake on both sides.
// Define ALU_MULDIV_EN to build the iterative RV32M multiply/divide unit.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  state_t          state_q, state_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            zf_q, zf_d;

  logic [XLEN-1:0] a, b, single_res;
  logic [SHW-1:0]  shamt;
  logic            md_go, md_done;
  logic [XLEN-1:0] md_res;

  assign a     = bus.A;
  assign b     = bus.B;
  assign shamt = b[SHW-1:0];

`ifdef ALU_MULDIV_EN
  logic            md_start, md_is_div, md_signed_div, md_a_signed, md_b_signed, md_hi;
  logic            div_zero, div_ovf, md_special;
  logic [XLEN-1:0] md_special_res;

  assign md_is_div     = bus.sel inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign md_signed_div = bus.sel inside {ALU_DIV, ALU_REM};
  assign md_a_signed   = bus.sel inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  assign md_b_signed   = bus.sel inside {ALU_MULH, ALU_DIV, ALU_REM};
  assign md_hi         = bus.sel inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};

  // Divide-by-zero and signed overflow have fixed answers and bypass the iteration.
  assign div_zero   = (b == '0);
  assign div_ovf    = md_signed_div && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign md_special = md_is_div && (div_zero || div_ovf);
  assign md_special_res = div_zero ? (md_hi ? a : '1) : (md_hi ? '0 : a);

  assign md_go    = is_muldiv(bus.sel) && !md_special;
  assign md_start = (state_q == IDLE) && bus.in_valid && md_go;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .is_div   (md_is_div),
    .a_signed (md_a_signed),
    .b_signed (md_b_signed),
    .hi       (md_hi),
    .a        (a),
    .b        (b),
    .done     (md_done),
    .result   (md_res)
  );

  assign bus.busy = (state_q == CALC);
`else
  assign md_go    = 1'b0;
  assign md_done  = 1'b0;
  assign md_res   = '0;
  assign bus.busy = 1'b0;
`endif

  always_comb begin
    single_res = '0;
    case (bus.sel)
      ALU_ADD:  single_res = a + b;
      ALU_SUB:  single_res = a - b;
      ALU_XOR:  single_res = a ^ b;
      ALU_OR:   single_res = a | b;
      ALU_AND:  single_res = a & b;
      ALU_SLL:  single_res = a << shamt;
      ALU_SRL:  single_res = a >> shamt;
      ALU_SRA:  single_res = XLEN'($signed(a) >>> shamt);
      ALU_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: single_res = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef ALU_MULDIV_EN
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: single_res = md_special_res;
`endif
      default:  single_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zf_d    = zf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (md_go) begin
            state_d = CALC;
          end else begin
            out_d   = single_res;
            zf_d    = (single_res == '0);
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (md_done) begin
          out_d   = md_res;
          zf_d    = (md_res == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zf_q    <= zf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.zeroflag  = zf_q;

endmodule
